hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 reset  in  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-003 ID_rs, ID_rt  in  5 each  source register fields of the instruction in ID.
REQ-004 ID_UsesRt  in  1  ID instruction reads rt (R-type, branch, store).
REQ-005 ID_Jump  in  1  jump decoded in ID.
REQ-006 EX_MemRead  in  1  instruction in EX is a load.
REQ-007 EX_WriteReg  in  5  destination register of the EX instruction.
REQ-008 EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-009 MEM_MemRead, MEM_MemWrite  in  1 each  memory access in MEM.
REQ-010 mem_ready  in  1  data memory completed the MEM-stage access this cycle.
REQ-011 PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall  out  1 each  hold the corresponding register.
REQ-012 IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble (all-zero control) into the register.
REQ-013 mem_timeout  out  1  sticky error: memory wait exceeded its limit.
REQ-014 stall_count, flush_count  out  16 each  saturating performance counters.

Function
REQ-015 Stall/flush outputs SHALL be combinational from the current inputs and state (0-cycle latency), so pipeline registers act at the same posedge.
REQ-016 mem_busy SHALL be (MEM_MemRead | MEM_MemWrite) & !mem_ready.
REQ-017 mem_busy=1 (freeze) SHALL assert PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall and MEM_WB_Flush, and deassert IF_ID_Flush and ID_EX_Flush; freeze has highest priority.
REQ-018 Otherwise EX_BranchTaken=1 SHALL assert IF_ID_Flush and ID_EX_Flush, with all stalls 0; it overrides load-use and jump.
REQ-019 Otherwise load-use, defined as EX_MemRead & EX_WriteReg!=0 & (EX_WriteReg==ID_rs | (ID_UsesRt & EX_WriteReg==ID_rt)), SHALL assert PC_Stall, IF_ID_Stall and ID_EX_Flush.
REQ-020 Otherwise ID_Jump=1 SHALL assert IF_ID_Flush only.
REQ-021 With none of these conditions, all stall/flush outputs SHALL be 0.
REQ-022 Load-use with EX_WriteReg=0 SHALL NOT stall.
REQ-023 Load-use and ID_Jump together SHALL produce a stall only; the jump is re-evaluated after the bubble.
REQ-024 FSM states: RUN, MEM_WAIT. RUN->MEM_WAIT when mem_busy; MEM_WAIT->RUN when mem_busy=0; otherwise the state is held.
REQ-025 An 8-bit wait counter SHALL clear on entering MEM_WAIT and increment each cycle in MEM_WAIT; when it reaches 255 with mem_busy still 1, mem_timeout SHALL set and remain set until reset.
REQ-026 The freeze outputs SHALL continue after timeout; the block SHALL NOT force progress.
REQ-027 stall_count SHALL increment by 1 on each cycle with PC_Stall=1.
REQ-028 flush_count SHALL increment by 1 on each cycle with IF_ID_Flush | ID_EX_Flush.
REQ-029 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.

Reset
REQ-030 On posedge clk with reset=0: state=RUN, wait counter=0, mem_timeout=0, stall_count=0, flush_count=0.
REQ-031 While reset=0, IF_ID_Flush=1 and ID_EX_Flush=1, and every stall output and MEM_WB_Flush SHALL be 0; counters do not count these cycles.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abort the wait; the next cycle with reset=1 starts in RUN.

Verification
REQ-033 EX_MemRead=1, EX_WriteReg=5, ID_rs=5 -> PC_Stall=1, IF_ID_Stall=1, ID_EX_Flush=1 for exactly that cycle; stall_count +1.
REQ-034 Same stimulus with EX_WriteReg=0 -> all outputs 0; the same stimulus plus EX_BranchTaken=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Stall=0; flush_count +1.
REQ-035 MEM_MemRead=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> freeze outputs asserted for 3 cycles; state MEM_WAIT, then RUN; stall_count +3.
REQ-036 mem_busy held for 300 cycles -> mem_timeout rises after 256 cycles in MEM_WAIT and stays 1 after mem_ready=1; clears only on reset=0.
REQ-037 PC_Stall forced continuously for 70000 cycles -> stall_count holds at 16'hFFFF.
REQ-038 reset=0 pulse during MEM_WAIT with counters nonzero -> at the next edge all counters and mem_timeout read 0, state RUN; IF_ID_Flush=ID_EX_Flush=1 while reset=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush, load-use stall and jump flush,
// with a memory-wait timeout monitor and saturating stall/flush performance counters.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRt,
   input  logic        ID_Jump,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_WriteReg,
   input  logic        EX_BranchTaken,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic        mem_ready,
   output logic        PC_Stall,
   output logic        IF_ID_Stall,
   output logic        ID_EX_Stall,
   output logic        EX_MEM_Stall,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Flush,
   output logic        MEM_WB_Flush,
   output logic        mem_timeout,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count,
   output logic        fsm_state
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t     state;
   logic [7:0] wait_cnt;
   logic       mem_busy;
   logic       load_use;

   assign mem_busy  = (MEM_MemRead | MEM_MemWrite) & ~mem_ready;
   assign load_use  = EX_MemRead & (EX_WriteReg != 5'd0) &
                      ((EX_WriteReg == ID_rs) | (ID_UsesRt & (EX_WriteReg == ID_rt)));
   assign fsm_state = (state == MEM_WAIT);

   // Priority: reset bubble, memory freeze, taken branch, load-use, jump.
   always_comb begin
      PC_Stall     = 1'b0;
      IF_ID_Stall  = 1'b0;
      ID_EX_Stall  = 1'b0;
      EX_MEM_Stall = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Flush  = 1'b0;
      MEM_WB_Flush = 1'b0;
      if (!reset) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (mem_busy) begin
         PC_Stall     = 1'b1;
         IF_ID_Stall  = 1'b1;
         ID_EX_Stall  = 1'b1;
         EX_MEM_Stall = 1'b1;
         MEM_WB_Flush = 1'b1;
      end else if (EX_BranchTaken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (load_use) begin
         PC_Stall    = 1'b1;
         IF_ID_Stall = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (ID_Jump) begin
         IF_ID_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
         stall_count <= 16'd0;
         flush_count <= 16'd0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (!mem_busy) begin
                  state <= RUN;
               end else begin
                  // Timeout only flags the error; the freeze keeps holding the pipeline.
                  if (wait_cnt == 8'hFF) mem_timeout <= 1'b1;
                  else                   wait_cnt    <= wait_cnt + 8'd1;
               end
            end
            default: state <= RUN;
         endcase
         if (PC_Stall && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
         if ((IF_ID_Flush || ID_EX_Flush) && (flush_count != 16'hFFFF))
            flush_count <= flush_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked every cycle against a
// rule-level model (busy-run length, sticky timeout, clamped counters).
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ID_rs, ID_rt, EX_WriteReg;
   logic        ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken;
   logic        MEM_MemRead, MEM_MemWrite, mem_ready;
   logic        PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall;
   logic        IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, mem_timeout, fsm_state;
   logic [15:0] stall_count, flush_count;

   int vectors = 0;
   int miscompares = 0;

   // Model state: consecutive busy cycles seen so far, sticky timeout, clamped counters.
   int m_busy_run;
   bit m_timeout;
   int m_stall;
   int m_flush;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
      .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg), .EX_BranchTaken(EX_BranchTaken),
      .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .mem_ready(mem_ready),
      .PC_Stall(PC_Stall), .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall),
      .EX_MEM_Stall(EX_MEM_Stall), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
      .MEM_WB_Flush(MEM_WB_Flush), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   function automatic bit busy_now();
      return (MEM_MemRead || MEM_MemWrite) && !mem_ready;
   endfunction

   // Expected {PC, IF_ID_S, ID_EX_S, EX_MEM_S, IF_ID_F, ID_EX_F, MEM_WB_F}.
   function automatic logic [6:0] exp_ctl();
      bit hit_rs, hit_rt, lu;
      hit_rs = (EX_WriteReg == ID_rs);
      hit_rt = ID_UsesRt && (EX_WriteReg == ID_rt);
      lu     = EX_MemRead && (EX_WriteReg != 0) && (hit_rs || hit_rt);
      if (!reset)         return 7'b0000110;
      if (busy_now())     return 7'b1111001;
      if (EX_BranchTaken) return 7'b0000110;
      if (lu)             return 7'b1100010;
      if (ID_Jump)        return 7'b0000100;
      return 7'b0000000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      reset = 1'b1;
      ID_rs = 0; ID_rt = 0; EX_WriteReg = 0;
      ID_UsesRt = 0; ID_Jump = 0; EX_MemRead = 0; EX_BranchTaken = 0;
      MEM_MemRead = 0; MEM_MemWrite = 0; mem_ready = 0;
   endtask

   // Inputs are already set (at the negedge); check this cycle, then advance one clock.
   task automatic tick();
      logic [6:0] ctl;
      #1;
      ctl = exp_ctl();
      vectors++;
      check("ctl", {25'd0, PC_Stall, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall,
                    IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush}, {25'd0, ctl});
      check("state", {31'd0, fsm_state}, {31'd0, m_busy_run > 0});
      check("timeout", {31'd0, mem_timeout}, {31'd0, m_timeout});
      check("stall_count", {16'd0, stall_count}, m_stall);
      check("flush_count", {16'd0, flush_count}, m_flush);
      @(posedge clk);
      if (!reset) begin
         m_busy_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (busy_now()) begin
            if (m_busy_run >= 256) m_timeout = 1;
            m_busy_run++;
         end else begin
            m_busy_run = 0;
         end
         if (ctl[6] && m_stall < 65535) m_stall++;
         if ((ctl[2] || ctl[1]) && m_flush < 65535) m_flush++;
      end
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      m_busy_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
      @(negedge clk);
      // Reset held: bubble flushes only, counters stay at zero.
      tick(); tick();
      reset = 1'b1;
      tick();

      // Load-use on rs, then the same with r0 destination, then with a taken branch.
      EX_MemRead = 1; EX_WriteReg = 5; ID_rs = 5;
      tick();
      EX_WriteReg = 0;
      tick();
      EX_WriteReg = 5; EX_BranchTaken = 1;
      tick();
      idle_inputs();
      // Load-use via rt, with and without ID_UsesRt, plus load-use combined with jump.
      EX_MemRead = 1; EX_WriteReg = 7; ID_rt = 7; ID_rs = 3; ID_UsesRt = 1;
      tick();
      ID_UsesRt = 0;
      tick();
      ID_UsesRt = 1; ID_Jump = 1;
      tick();
      EX_MemRead = 0;
      tick();
      idle_inputs();

      // Three-cycle memory wait, then completion.
      MEM_MemRead = 1;
      repeat (3) tick();
      mem_ready = 1;
      tick();
      idle_inputs();
      tick();

      // Long store wait: timeout must rise and stay set after the access completes.
      MEM_MemWrite = 1;
      repeat (300) tick();
      mem_ready = 1;
      repeat (3) tick();
      idle_inputs();
      tick();
      // Reset pulse in the middle of a wait with nonzero counters.
      MEM_MemRead = 1;
      repeat (4) tick();
      reset = 1'b0;
      tick();
      idle_inputs();
      repeat (2) tick();

      // Continuous load-use stall long enough to saturate both counters.
      EX_MemRead = 1; EX_WriteReg = 9; ID_rs = 9;
      repeat (65600) tick();
      idle_inputs();
      tick();

      // Random traffic with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         reset          = ($urandom_range(0, 199) != 0);
         ID_rs          = 5'($urandom_range(0, 3));
         ID_rt          = 5'($urandom_range(0, 3));
         EX_WriteReg    = 5'($urandom_range(0, 3));
         ID_UsesRt      = $urandom_range(0, 1) != 0;
         ID_Jump        = $urandom_range(0, 4) == 0;
         EX_MemRead     = $urandom_range(0, 1) != 0;
         EX_BranchTaken = $urandom_range(0, 5) == 0;
         MEM_MemRead    = $urandom_range(0, 3) == 0;
         MEM_MemWrite   = $urandom_range(0, 5) == 0;
         mem_ready      = $urandom_range(0, 2) != 0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
